ili9341_rx: RTL
===============

ILI9341_RX -- requirements
Module: ili9341_rx

Interface
REQ-001 Parameter COLS_, default 240, display columns (pixel address stride).
REQ-002 Parameter ROWS_, default 320, display rows.
REQ-003 CLK_I  input  1  system clock; all state on rising edge.
REQ-004 RST_I  input  1  asynchronous, active-low reset; one clock.
REQ-005 tftChipSelect  input  1  SPI chip select, active low, asynchronous to CLK_I.
REQ-006 tftSck  input  1  SPI clock, mode 0, MOSI sampled on rising edge.
REQ-007 tftMosi  input  1  SPI data, MSB first.
REQ-008 dataCtrl  input  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
REQ-009 cmdByte  output  8  last received command byte.
REQ-010 cmdStrobe  output  1  one-cycle pulse, cmdByte valid.
REQ-011 paramByte  output  8  last received data byte outside RAMWR.
REQ-012 paramStrobe  output  1  one-cycle pulse, paramByte valid.
REQ-013 pixelAddr  output  17  row*COLS_+col of the pixel being written.
REQ-014 pixelData  output  16  RGB565 pixel, first byte in [15:8].
REQ-015 pixelWe  output  1  one-cycle pixel write strobe.

Function
REQ-016 The block SHALL pass tftChipSelect, tftSck, tftMosi, dataCtrl through two-flop synchronizers before use.
REQ-017 The block SHALL detect tftSck rising edges from the synchronized signal; inputs require SCK high and low ≥3 CLK_I periods each.
REQ-018 On each detected edge with chip select low, the block SHALL shift synchronized tftMosi into an 8-bit shift register and increment a 3-bit bit counter.
REQ-019 On the 8th bit, the block SHALL complete the byte and raise the relevant strobe on the cycle following edge detection (3 CLK_I cycles after the pin edge).
REQ-020 Chip select high SHALL clear the bit counter and discard any partial byte; decoder state, window and cursor SHALL be retained.
REQ-021 Decoder states: IDLE, CASET (0x2A), PASET (0x2B), RAMWR (0x2C), OTHER.
REQ-022 Any command byte SHALL pulse cmdStrobe, reset the parameter counter and pixel-byte phase, and enter the state for that command (unlisted codes -> OTHER).
REQ-023 In CASET, data bytes 0..3 SHALL load SC[15:8], SC[7:0], EC[15:8], EC[7:0]; further bytes ignored for the window; paramStrobe pulses for every byte.
REQ-024 In PASET, data bytes 0..3 SHALL likewise load SP and EP.
REQ-025 In IDLE and OTHER, data bytes SHALL pulse paramStrobe only.
REQ-026 Entering RAMWR SHALL set cursor col=SC, row=SP.
REQ-027 In RAMWR, even data bytes SHALL be held as high byte; odd bytes SHALL complete pixelData and pulse pixelWe with pixelAddr of the current cursor; paramStrobe SHALL not pulse.
REQ-028 After each pixel, col SHALL increment; at col==EC col SHALL wrap to SC and row increment; at row==EP and col==EC both SHALL wrap to (SC,SP).
REQ-029 If EC<SC, col SHALL stay at SC and row advance every pixel; if EP<SP, row SHALL stay at SP.
REQ-030 If col≥COLS_ or row≥ROWS_, pixelWe SHALL be suppressed but the cursor SHALL still advance.
REQ-031 pixelAddr SHALL be computed in 17 bits with no overflow for in-range cursors (max 76799).
REQ-032 Strobes SHALL never be asserted for two consecutive cycles from one byte.

Reset
REQ-033 While RST_I low: all outputs 0, state IDLE, bit counter 0, SC=0, EC=COLS_-1, SP=0, EP=ROWS_-1, cursor (0,0), synchronizers cleared (chip select sync to 1).
REQ-034 Reset asserted mid-byte or mid-pixel SHALL discard the partial byte/pixel; first byte after release is decoded fresh.

Verification
REQ-035 Reset, then CS low, command 0x2C, data 0xF8 0x00 -> cmdStrobe with cmdByte=0x2C; one pixelWe, pixelAddr=0, pixelData=0xF800.
REQ-036 0x2A with 00 0A 00 0B, 0x2B with 00 05 00 06, 0x2C, 5 pixels -> pixelAddr 1210,1211,1450,1451,1210.
REQ-037 CS high after 5 bits of a data byte, then CS low and full byte 0xAB (dc=1, state OTHER) -> single paramStrobe, paramByte=0xAB, no partial strobe.
REQ-038 CASET 00 F0 00 F5 then RAMWR, 2 pixels -> no pixelWe, cursor at col 242; then CASET 0..239 and RAMWR 1 pixel -> pixelWe at addr 0.
REQ-039 Window 0..239 x 0..319, RAMWR 76801 pixels -> last pixelWe addr 76799 followed by addr 0.
REQ-040 RST_I low for one cycle between first and second byte of a RAMWR pixel -> no pixelWe; window reset to full screen; outputs 0.

Source files
------------

// File: rtl/ili9341_rx.sv
// ILI9341 SPI write-side receiver: recovers command/data bytes from a 4-wire SPI
// bus and turns RAMWR payloads into addressed RGB565 pixel writes.
module ili9341_rx #(
    parameter int COLS_ = 240,
    parameter int ROWS_ = 320
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        tftChipSelect,
    input  logic        tftSck,
    input  logic        tftMosi,
    input  logic        dataCtrl,
    output logic [7:0]  cmdByte,
    output logic        cmdStrobe,
    output logic [7:0]  paramByte,
    output logic        paramStrobe,
    output logic [16:0] pixelAddr,
    output logic [15:0] pixelData,
    output logic        pixelWe
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CASET = 3'd1;
    localparam logic [2:0] ST_PASET = 3'd2;
    localparam logic [2:0] ST_RAMWR = 3'd3;
    localparam logic [2:0] ST_OTHER = 3'd4;

    localparam logic [15:0] EC_RST = 16'(COLS_ - 1);
    localparam logic [15:0] EP_RST = 16'(ROWS_ - 1);
    localparam logic [16:0] COLS_L = 17'(COLS_);
    localparam logic [16:0] ROWS_L = 17'(ROWS_);

    logic [1:0]  cs_sync_q, sck_sync_q, mosi_sync_q, dc_sync_q;
    logic        sck_prev_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;

    logic [2:0]  state_q, state_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] col_q, col_d, row_q, row_d;

    logic [7:0]  cmd_byte_q, cmd_byte_d, param_byte_q, param_byte_d;
    logic        cmd_strobe_q, cmd_strobe_d, param_strobe_q, param_strobe_d;
    logic [16:0] pixel_addr_q, pixel_addr_d;
    logic [15:0] pixel_data_q, pixel_data_d;
    logic        pixel_we_q, pixel_we_d;

    logic        cs_active, sck_rise, shift_en, byte_done, byte_is_data;
    logic [7:0]  byte_val;
    logic        wrap_col, wrap_row, in_range;
    logic [15:0] col_adv, row_adv;
    logic [16:0] addr_calc;

    assign cs_active    = ~cs_sync_q[1];
    assign sck_rise     = sck_sync_q[1] & ~sck_prev_q;
    assign shift_en     = sck_rise & cs_active;
    assign byte_done    = shift_en && (bit_cnt_q == 3'd7);
    assign byte_val     = {shift_q[6:0], mosi_sync_q[1]};
    assign byte_is_data = dc_sync_q[1];

    // Degenerate windows (end < start) pin that axis to its start coordinate.
    assign wrap_col  = (col_q == ec_q) || (ec_q < sc_q);
    assign wrap_row  = (row_q == ep_q) || (ep_q < sp_q);
    assign col_adv   = wrap_col ? sc_q : col_q + 16'd1;
    assign row_adv   = wrap_col ? (wrap_row ? sp_q : row_q + 16'd1) : row_q;
    assign in_range  = ({1'b0, col_q} < COLS_L) && ({1'b0, row_q} < ROWS_L);
    assign addr_calc = 17'(row_q) * COLS_L + 17'(col_q);

    always_comb begin
        state_d        = state_q;
        pcnt_d         = pcnt_q;
        phase_d        = phase_q;
        hi_d           = hi_q;
        sc_d           = sc_q;
        ec_d           = ec_q;
        sp_d           = sp_q;
        ep_d           = ep_q;
        col_d          = col_q;
        row_d          = row_q;
        cmd_byte_d     = cmd_byte_q;
        cmd_strobe_d   = 1'b0;
        param_byte_d   = param_byte_q;
        param_strobe_d = 1'b0;
        pixel_addr_d   = pixel_addr_q;
        pixel_data_d   = pixel_data_q;
        pixel_we_d     = 1'b0;
        if (byte_done) begin
            if (!byte_is_data) begin
                cmd_byte_d   = byte_val;
                cmd_strobe_d = 1'b1;
                pcnt_d       = 3'd0;
                phase_d      = 1'b0;
                case (byte_val)
                    8'h2A:   state_d = ST_CASET;
                    8'h2B:   state_d = ST_PASET;
                    8'h2C: begin
                        state_d = ST_RAMWR;
                        col_d   = sc_q;
                        row_d   = sp_q;
                    end
                    default: state_d = ST_OTHER;
                endcase
            end else if (state_q == ST_RAMWR) begin
                if (!phase_q) begin
                    hi_d    = byte_val;
                    phase_d = 1'b1;
                end else begin
                    phase_d      = 1'b0;
                    pixel_data_d = {hi_q, byte_val};
                    pixel_addr_d = addr_calc;
                    pixel_we_d   = in_range;
                    col_d        = col_adv;
                    row_d        = row_adv;
                end
            end else begin
                param_byte_d   = byte_val;
                param_strobe_d = 1'b1;
                if (pcnt_q < 3'd4) begin
                    pcnt_d = pcnt_q + 3'd1;
                    if (state_q == ST_CASET) begin
                        case (pcnt_q[1:0])
                            2'd0:    sc_d = {byte_val, sc_q[7:0]};
                            2'd1:    sc_d = {sc_q[15:8], byte_val};
                            2'd2:    ec_d = {byte_val, ec_q[7:0]};
                            default: ec_d = {ec_q[15:8], byte_val};
                        endcase
                    end else if (state_q == ST_PASET) begin
                        case (pcnt_q[1:0])
                            2'd0:    sp_d = {byte_val, sp_q[7:0]};
                            2'd1:    sp_d = {sp_q[15:8], byte_val};
                            2'd2:    ep_d = {byte_val, ep_q[7:0]};
                            default: ep_d = {ep_q[15:8], byte_val};
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cs_sync_q      <= 2'b11;
            sck_sync_q     <= 2'b00;
            mosi_sync_q    <= 2'b00;
            dc_sync_q      <= 2'b00;
            sck_prev_q     <= 1'b0;
            shift_q        <= 8'h00;
            bit_cnt_q      <= 3'd0;
            state_q        <= ST_IDLE;
            pcnt_q         <= 3'd0;
            phase_q        <= 1'b0;
            hi_q           <= 8'h00;
            sc_q           <= 16'd0;
            ec_q           <= EC_RST;
            sp_q           <= 16'd0;
            ep_q           <= EP_RST;
            col_q          <= 16'd0;
            row_q          <= 16'd0;
            cmd_byte_q     <= 8'h00;
            cmd_strobe_q   <= 1'b0;
            param_byte_q   <= 8'h00;
            param_strobe_q <= 1'b0;
            pixel_addr_q   <= 17'd0;
            pixel_data_q   <= 16'h0000;
            pixel_we_q     <= 1'b0;
        end else begin
            cs_sync_q      <= {cs_sync_q[0], tftChipSelect};
            sck_sync_q     <= {sck_sync_q[0], tftSck};
            mosi_sync_q    <= {mosi_sync_q[0], tftMosi};
            dc_sync_q      <= {dc_sync_q[0], dataCtrl};
            sck_prev_q     <= sck_sync_q[1];
            // Deselect drops any partial byte; decoder context survives.
            if (!cs_active) begin
                bit_cnt_q <= 3'd0;
            end else if (shift_en) begin
                shift_q   <= byte_val;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            state_q        <= state_d;
            pcnt_q         <= pcnt_d;
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            sc_q           <= sc_d;
            ec_q           <= ec_d;
            sp_q           <= sp_d;
            ep_q           <= ep_d;
            col_q          <= col_d;
            row_q          <= row_d;
            cmd_byte_q     <= cmd_byte_d;
            cmd_strobe_q   <= cmd_strobe_d;
            param_byte_q   <= param_byte_d;
            param_strobe_q <= param_strobe_d;
            pixel_addr_q   <= pixel_addr_d;
            pixel_data_q   <= pixel_data_d;
            pixel_we_q     <= pixel_we_d;
        end
    end

    assign cmdByte     = cmd_byte_q;
    assign cmdStrobe   = cmd_strobe_q;
    assign paramByte   = param_byte_q;
    assign paramStrobe = param_strobe_q;
    assign pixelAddr   = pixel_addr_q;
    assign pixelData   = pixel_data_q;
    assign pixelWe     = pixel_we_q;

endmodule
